// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Shared definitions for the crossbar test top: command encodings, the
// transaction FSM state type, the data width and the slave-select bit
// position inside the external address.
// ---------------------------------------------------------------------------
package xbar_pkg;

    // Data path width; every slave word is this wide.
    localparam int DW = 32;

    // External address bit that picks RAM1 (1) over RAM0 (0).
    localparam int SEL_BIT = 31;

    // Master command encodings carried on t_cmd.
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Transaction FSM: wait for a request, perform the RAM access while
    // acknowledging, then (reads only) present the response for one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/xbar_ram.sv
// ---------------------------------------------------------------------------
// xbar_ram
// Single-port synchronous RAM used as one crossbar slave. Holds 2**AW words
// of DW bits. Nothing happens unless en is high: with we high the addressed
// word is written, with we low the addressed word is copied into the rdata
// register. rdata therefore keeps the last read value across idle cycles and
// writes. Contents and rdata are not reset.
//
// Ports
//   clk    in   1    clock, rising edge
//   en     in   1    access enable (this slave selected and FSM in ACCESS)
//   we     in   1    1 = write, 0 = read (only meaningful while en)
//   addr   in   AW   word index
//   wdata  in   DW   write data
//   rdata  out  DW   registered read data
// ---------------------------------------------------------------------------
module xbar_ram
    import xbar_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // A write leaves rdata alone, so the crossbar can rely on rdata still
    // holding the most recent read result when it is not being refreshed.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top
// Crossbar test top: one external master port (t_*) feeding a 1-to-2
// address-decoded interconnect with two internal word-addressed RAM slaves.
// Address bit 31 selects the slave, the low AW bits index the word and the
// bits in between are ignored, so they alias onto the same word.
//
// Ports
//   clk      in   1    system clock, rising edge
//   reset    in   1    asynchronous reset, active low
//   t_req    in   1    request, held by the master until t_ack
//   t_cmd    in   1    0 = read, 1 = write
//   t_addr   in   32   bit31 slave select, [AW-1:0] word index
//   t_wdata  in   32   write data
//   t_ack    out  1    one-cycle acknowledge, cycle after the request edge
//   t_resp   out  1    one-cycle read-data strobe, two cycles after request
//   t_rdata  out  32   read data, holds last read value, 0 after reset
// ---------------------------------------------------------------------------
module top
    import xbar_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          t_req,
    input  logic          t_cmd,
    input  logic [31:0]   t_addr,
    input  logic [DW-1:0] t_wdata,
    output logic          t_ack,
    output logic          t_resp,
    output logic [DW-1:0] t_rdata
);

    state_t        state_q;
    logic          cmd_q;
    logic          sel_q;
    logic [AW-1:0] idx_q;
    logic [DW-1:0] wdata_q;
    logic          ack_q;
    logic          resp_q;
    logic          rdValid_q;
    logic          rdSel_q;

    logic          ram0En;
    logic          ram1En;
    logic          ramWe;
    logic [DW-1:0] ram0Rdata;
    logic [DW-1:0] ram1Rdata;

    // The address bits between the word index and the select bit are
    // deliberately dropped; folding them into a named sink keeps that
    // decision visible instead of leaving a silently dangling input range.
    logic unusedAddrBits;
    assign unusedAddrBits = ^t_addr[SEL_BIT-1:AW];

    // Transaction FSM with registered strobes. The request is captured only
    // in IDLE, so the master's inputs are free to change once acknowledged.
    // Reads arm rdValid_q/rdSel_q on the same edge the RAM loads its rdata
    // register; reset clears rdValid_q so t_rdata reads as 0 immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_READ;
            sel_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            resp_q    <= 1'b0;
            rdValid_q <= 1'b0;
            rdSel_q   <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (t_req) begin
                        state_q <= ACCESS;
                        ack_q   <= 1'b1;
                        cmd_q   <= t_cmd;
                        sel_q   <= t_addr[SEL_BIT];
                        idx_q   <= t_addr[AW-1:0];
                        wdata_q <= t_wdata;
                    end
                end
                ACCESS: begin
                    if (cmd_q == CMD_READ) begin
                        state_q   <= RESP;
                        resp_q    <= 1'b1;
                        rdValid_q <= 1'b1;
                        rdSel_q   <= sel_q;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Only the decoded slave sees an enable, and only during ACCESS, so an
    // asynchronous reset that drops the FSM to IDLE also cancels a pending
    // write before its edge.
    always_comb begin
        ram0En = (state_q == ACCESS) && (sel_q == 1'b0);
        ram1En = (state_q == ACCESS) && (sel_q == 1'b1);
        ramWe  = (cmd_q == CMD_WRITE);
    end

    xbar_ram #(
        .AW (AW)
    ) u_ram0 (
        .clk   (clk),
        .en    (ram0En),
        .we    (ramWe),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram0Rdata)
    );

    xbar_ram #(
        .AW (AW)
    ) u_ram1 (
        .clk   (clk),
        .en    (ram1En),
        .we    (ramWe),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram1Rdata)
    );

    // Each RAM holds its own last read value, so the response mux follows
    // the slave of the most recent read rather than the current request.
    always_comb begin
        t_ack   = ack_q;
        t_resp  = resp_q;
        t_rdata = '0;
        if (rdValid_q) begin
            t_rdata = rdSel_q ? ram1Rdata : ram0Rdata;
        end
    end

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top
// Directed bench for the crossbar test top. Inputs change 1 ns after a rising
// edge and outputs are checked at that same point, i.e. they show what the
// preceding edge produced.
// ---------------------------------------------------------------------------
module tb_top;
    import xbar_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        t_req;
    logic        t_cmd;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_ack;
    logic        t_resp;
    logic [31:0] t_rdata;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    top #(
        .AW (11)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .t_req   (t_req),
        .t_cmd   (t_cmd),
        .t_addr  (t_addr),
        .t_wdata (t_wdata),
        .t_ack   (t_ack),
        .t_resp  (t_resp),
        .t_rdata (t_rdata)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive the master port.
    task automatic applyStimulus(input logic req, input logic cmd,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        t_req   = req;
        t_cmd   = cmd;
        t_addr  = addr;
        t_wdata = wdata;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    // Single write from IDLE: ack in the cycle after the request edge, no resp.
    task automatic writeWord(input string tag, input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, CMD_WRITE, addr, data);
        nextEdge();
        checkOutput({tag, "_ack"}, 32'(t_ack), 32'd1);
        checkOutput({tag, "_resp"}, 32'(t_resp), 32'd0);
        applyStimulus(1'b0, CMD_READ, 32'd0, 32'd0);
        nextEdge();
        checkOutput({tag, "_ackLow"}, 32'(t_ack), 32'd0);
    endtask

    // Single read from IDLE: ack at N+1, resp with data at N+2, data held after.
    task automatic readWord(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b1, CMD_READ, addr, 32'd0);
        nextEdge();
        checkOutput({tag, "_ack"}, 32'(t_ack), 32'd1);
        checkOutput({tag, "_respEarly"}, 32'(t_resp), 32'd0);
        applyStimulus(1'b0, CMD_READ, 32'd0, 32'd0);
        nextEdge();
        checkOutput({tag, "_resp"}, 32'(t_resp), 32'd1);
        checkOutput({tag, "_ackLow"}, 32'(t_ack), 32'd0);
        checkOutput({tag, "_data"}, t_rdata, expected);
        nextEdge();
        checkOutput({tag, "_respLow"}, 32'(t_resp), 32'd0);
        checkOutput({tag, "_hold"}, t_rdata, expected);
    endtask

    // Safety net in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] b2bAddr [3];
    logic [31:0] b2bData [3];
    logic        ackSeen [6];
    logic        respSeen;

    initial begin
        b2bAddr[0] = 32'h0000_0100; b2bData[0] = 32'h0000_00B0;
        b2bAddr[1] = 32'h0000_0101; b2bData[1] = 32'h0000_00B1;
        b2bAddr[2] = 32'h8000_0102; b2bData[2] = 32'h0000_00B2;

        // Reset with unknown master inputs.
        reset = 1'b0;
        applyStimulus(1'bx, 1'bx, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ack", 32'(t_ack), 32'd0);
        checkOutput("rst_resp", 32'(t_resp), 32'd0);
        checkOutput("rst_rdata", t_rdata, 32'd0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
        applyStimulus(1'b0, CMD_READ, 32'd0, 32'd0);
        reset = 1'b1;
        nextEdge();

        // Basic write then read-back on RAM0.
        writeWord("wr1342", 32'd1342, 32'd9105);
        readWord("rd1342", 32'd1342, 32'd9105);

        // Slave decode: same index in both RAMs.
        writeWord("wrS1", 32'h8000_0010, 32'hA5A5_A5A5);
        writeWord("wrS0", 32'h0000_0010, 32'h1111_1111);
        readWord("rdS1", 32'h8000_0010, 32'hA5A5_A5A5);
        readWord("rdS0", 32'h0000_0010, 32'h1111_1111);

        // Aliasing of the ignored middle address bits.
        writeWord("wrAlias", 32'h0000_0805, 32'd7);
        readWord("rdAlias", 32'h0000_0005, 32'd7);

        // A later write must not disturb the held read data.
        writeWord("wrOther", 32'h8000_0020, 32'h2222_2222);
        checkOutput("holdAfterWr", t_rdata, 32'd7);

        // Back-to-back writes with t_req held high: acks in cycles 1, 3, 5.
        respSeen = 1'b0;
        applyStimulus(1'b1, CMD_WRITE, b2bAddr[0], b2bData[0]);
        for (int c = 0; c < 6; c++) begin
            nextEdge();
            ackSeen[c] = t_ack;
            if (t_resp) respSeen = 1'b1;
            if (c == 0) applyStimulus(1'b1, CMD_WRITE, b2bAddr[1], b2bData[1]);
            if (c == 2) applyStimulus(1'b1, CMD_WRITE, b2bAddr[2], b2bData[2]);
            if (c == 4) applyStimulus(1'b0, CMD_READ, 32'd0, 32'd0);
        end
        checkOutput("b2b_ack1", 32'(ackSeen[0]), 32'd1);
        checkOutput("b2b_ack2", 32'(ackSeen[1]), 32'd0);
        checkOutput("b2b_ack3", 32'(ackSeen[2]), 32'd1);
        checkOutput("b2b_ack4", 32'(ackSeen[3]), 32'd0);
        checkOutput("b2b_ack5", 32'(ackSeen[4]), 32'd1);
        checkOutput("b2b_ack6", 32'(ackSeen[5]), 32'd0);
        checkOutput("b2b_noResp", 32'(respSeen), 32'd0);
        readWord("rdB0", b2bAddr[0], b2bData[0]);
        readWord("rdB1", b2bAddr[1], b2bData[1]);
        readWord("rdB2", b2bAddr[2], b2bData[2]);

        // Reset during a write's ACCESS cycle: the write is dropped.
        applyStimulus(1'b1, CMD_WRITE, 32'd1342, 32'h0000_DEAD);
        nextEdge();
        checkOutput("abortWr_ack", 32'(t_ack), 32'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("abortWr_ackDrop", 32'(t_ack), 32'd0);
        applyStimulus(1'b0, CMD_READ, 32'd0, 32'd0);
        #2 reset = 1'b1;
        nextEdge();
        readWord("rdAfterAbortWr", 32'd1342, 32'd9105);

        // Reset during a read's ACCESS cycle: ack and rdata drop at once, no resp.
        applyStimulus(1'b1, CMD_READ, 32'h0000_0010, 32'd0);
        nextEdge();
        checkOutput("abortRd_ack", 32'(t_ack), 32'd1);
        checkOutput("abortRd_prevData", t_rdata, 32'd9105);
        #1 reset = 1'b0;
        #1;
        checkOutput("abortRd_ackDrop", 32'(t_ack), 32'd0);
        checkOutput("abortRd_rdataZero", t_rdata, 32'd0);
        checkOutput("abortRd_resp", 32'(t_resp), 32'd0);
        applyStimulus(1'b0, CMD_READ, 32'd0, 32'd0);
        #2 reset = 1'b1;
        respSeen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nextEdge();
            if (t_resp) respSeen = 1'b1;
        end
        checkOutput("abortRd_noResp", 32'(respSeen), 32'd0);
        checkOutput("abortRd_rdataStill0", t_rdata, 32'd0);

        // Recovery after the aborted read.
        readWord("rdRecover", 32'h8000_0010, 32'hA5A5_A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
